// File: rtl/sfifo_gen_if.sv
// Bus bundle for the sfifo_gen single-clock FIFO: write side, read side,
// occupancy/flag outputs and the sticky-error controls.
interface sfifo_gen_if #(
    parameter int D_WIDTH = 8,
    parameter int ADDRS   = 4
);
    // Handshake: a push (pop) is taken on a rising edge only when push (pop) is
    // high and full (empty) is low as seen before that edge; flush overrides both.
    logic               push;
    logic [D_WIDTH-1:0] wr_data;
    logic               pop;
    logic [D_WIDTH-1:0] rd_data;
    logic               rd_valid;
    logic               flush;
    logic               clr_err;
    logic [ADDRS:0]     count;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic               overflow;
    logic               underflow;

    modport master (
        output push, wr_data, pop, flush, clr_err,
        input  rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  push, wr_data, pop, flush, clr_err,
        output rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sfifo_gen.sv
// Parametrised single-clock FIFO with count, almost flags, sticky errors and a
// read port selectable between registered read and first-word-fall-through.
module sfifo_gen #(
    parameter int D_WIDTH   = 8,
    parameter int ADDRS     = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic        clk,
    input  logic        rst,
    sfifo_gen_if.slave  bus
);
    localparam int             DEPTH   = 2 ** ADDRS;
    localparam logic [ADDRS:0] C_DEPTH = (ADDRS + 1)'(DEPTH);
    localparam logic [ADDRS:0] C_AF    = (ADDRS + 1)'(AF_THRESH);
    localparam logic [ADDRS:0] C_AE    = (ADDRS + 1)'(AE_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sfifo_gen: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("sfifo_gen: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDRS-1:0]   r_wr_ptr;
    logic [ADDRS-1:0]   r_rd_ptr;
    logic [ADDRS:0]     r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_ovf_evt;
    logic               w_unf_evt;
    logic [ADDRS:0]     w_count_nxt;

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == '0);
    // Flush swallows both requests, so it can neither move data nor raise an error.
    assign w_push_ok = bus.push && !w_full  && !bus.flush;
    assign w_pop_ok  = bus.pop  && !w_empty && !bus.flush;
    assign w_ovf_evt = bus.push && w_full   && !bus.flush;
    assign w_unf_evt = bus.pop  && w_empty  && !bus.flush;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= w_count_nxt;
            end
            // A new error event outranks a clear arriving in the same cycle.
            if (w_ovf_evt)        r_overflow  <= 1'b1;
            else if (bus.clr_err) r_overflow  <= 1'b0;
            if (w_unf_evt)        r_underflow <= 1'b1;
            else if (bus.clr_err) r_underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= bus.wr_data;
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is shown as soon as it exists; zero while empty keeps reset clean.
        assign bus.rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
        assign bus.rd_valid = !w_empty;
    end else begin : g_reg
        logic [D_WIDTH-1:0] r_rd_data;
        logic               r_rd_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_pop_ok;
                if (w_pop_ok) r_rd_data <= r_mem[r_rd_ptr];
            end
        end

        assign bus.rd_data  = r_rd_data;
        assign bus.rd_valid = r_rd_valid;
    end

    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= C_AF);
    assign bus.almost_empty = (r_count <= C_AE);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sfifo_gen.sv
// Self-checking bench for sfifo_gen: a registered-read instance driven against a
// queue reference with a read-data scoreboard, plus a first-word-fall-through instance.
module tb_sfifo_gen;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sfifo_gen_if #(.D_WIDTH(8), .ADDRS(4)) b0 ();
    sfifo_gen_if #(.D_WIDTH(8), .ADDRS(4)) b1 ();

    sfifo_gen #(.D_WIDTH(8), .ADDRS(4), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    sfifo_gen #(.D_WIDTH(8), .ADDRS(4), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_unf;
    bit         m_rv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Registered-read instance: apply one cycle, update the queue reference, check flags.
    task automatic step0(input bit p, input logic [7:0] d, input bit q, input bit fl,
                         input bit ce, input string tag);
        bit full_b;
        bit empty_b;
        int sz;
        full_b  = (mq.size() == 16);
        empty_b = (mq.size() == 0);
        m_rv    = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (q && !empty_b) begin
                exp_q.push_back(mq.pop_front());
                m_rv = 1'b1;
            end
            if (p && !full_b) mq.push_back(d);
        end
        if (ce) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (!fl && p && full_b)  m_ovf = 1'b1;
        if (!fl && q && empty_b) m_unf = 1'b1;

        b0.push    = p;
        b0.wr_data = d;
        b0.pop     = q;
        b0.flush   = fl;
        b0.clr_err = ce;
        @(posedge clk);
        #1;
        b0.push    = 1'b0;
        b0.pop     = 1'b0;
        b0.flush   = 1'b0;
        b0.clr_err = 1'b0;

        sz = mq.size();
        check({tag, "_count"}, 32'(b0.count), 32'(sz));
        check({tag, "_flags"},
              32'({b0.full, b0.empty, b0.almost_full, b0.almost_empty,
                   b0.overflow, b0.underflow, b0.rd_valid}),
              32'({sz == 16, sz == 0, sz >= 12, sz <= 2, m_ovf, m_unf, m_rv}));
    endtask

    task automatic step1(input bit p, input logic [7:0] d, input bit q, input bit ce);
        b1.push    = p;
        b1.wr_data = d;
        b1.pop     = q;
        b1.clr_err = ce;
        @(posedge clk);
        #1;
        b1.push    = 1'b0;
        b1.pop     = 1'b0;
        b1.clr_err = 1'b0;
    endtask

    // Read-data scoreboard for the registered-read instance.
    always @(negedge clk) begin
        if (b0.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_data_unexpected: got 0x%0h expected no valid word", b0.rd_data);
            end else begin
                check("rd_data", 32'(b0.rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        b0.push = 1'b0; b0.wr_data = '0; b0.pop = 1'b0; b0.flush = 1'b0; b0.clr_err = 1'b0;
        b1.push = 1'b0; b1.wr_data = '0; b1.pop = 1'b0; b1.flush = 1'b0; b1.clr_err = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        #12;
        check("rst_count", 32'(b0.count), 32'd0);
        check("rst_flags", 32'({b0.full, b0.empty, b0.almost_full, b0.almost_empty,
                                b0.overflow, b0.underflow, b0.rd_valid}), 32'b0101000);
        check("rst_rd_data", 32'(b0.rd_data), 32'd0);
        check("rst_fwft", 32'({b1.rd_valid, b1.empty, b1.rd_data}), 32'h100);
        @(negedge clk);
        rst = 1'b0;

        // Fill to capacity, then overflow.
        for (int i = 1; i <= 16; i++) begin
            step0(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
            if (i == 11) check("af_before_12", 32'(b0.almost_full), 32'd0);
            if (i == 12) check("af_at_12", 32'(b0.almost_full), 32'd1);
        end
        check("fill_count16", 32'(b0.count), 32'd16);
        check("fill_full", 32'(b0.full), 32'd1);
        step0(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "ovf");
        check("ovf_set", 32'(b0.overflow), 32'd1);
        check("ovf_count", 32'(b0.count), 32'd16);
        step0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_ovf");
        for (int i = 0; i < 16; i++) step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
        check("drain_empty", 32'(b0.empty), 32'd1);
        step0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "idle");
        check("rd_hold", 32'(b0.rd_data), 32'h10);

        // Wrap with occupancy held at three.
        for (int i = 0; i < 3; i++) step0(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "wrap_fill");
        for (int i = 0; i < 37; i++) step0(1'b1, 8'(i + 3), 1'b1, 1'b0, 1'b0, "wrap");
        check("wrap_count3", 32'(b0.count), 32'd3);
        for (int i = 0; i < 3; i++) step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "wrap_drain");

        // Simultaneous push+pop at full.
        for (int i = 0; i < 16; i++) step0(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, "sim_fill");
        step0(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, "sim_full");
        check("sim_full_count", 32'(b0.count), 32'd15);
        check("sim_full_ovf", 32'(b0.overflow), 32'd1);

        // Flush with a concurrent push, right after a pop.
        step0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr");
        for (int i = 0; i < 8; i++) step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_to7");
        check("pre_flush_count", 32'(b0.count), 32'd7);
        step0(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, "flush");
        check("flush_state", 32'({b0.count, b0.empty, b0.overflow, b0.underflow, b0.rd_valid}),
              32'({5'd0, 4'b1000}));

        // Simultaneous push+pop at empty, then set-vs-clear priority.
        step0(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "sim_empty");
        check("sim_empty_count", 32'(b0.count), 32'd1);
        check("sim_empty_unf", 32'(b0.underflow), 32'd1);
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop55");
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "unf_clr");
        check("unf_set_wins", 32'(b0.underflow), 32'd1);
        step0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_unf");
        check("unf_cleared", 32'(b0.underflow), 32'd0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 10; i++) step0(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, "pre_rst_fill");
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pre_rst");
        check("pre_rst_state", 32'({b0.count, b0.rd_valid}), 32'({5'd9, 1'b1}));
        @(negedge clk);
        #1;
        rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        #1;
        check("mid_rst_count", 32'(b0.count), 32'd0);
        check("mid_rst_flags", 32'({b0.full, b0.empty, b0.almost_full, b0.almost_empty,
                                    b0.overflow, b0.underflow, b0.rd_valid}), 32'b0101000);
        check("mid_rst_rd_data", 32'(b0.rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step0(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, "post_rst_push");
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "post_rst_pop");
        step0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "post_rst_idle");

        // First-word-fall-through instance.
        step1(1'b1, 8'h3C, 1'b0, 1'b0);
        check("fwft_push", 32'({b1.rd_data, b1.rd_valid, b1.empty}), 32'({8'h3C, 2'b10}));
        step1(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_pop", 32'({b1.rd_valid, b1.empty}), 32'b01);
        step1(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_unf", 32'(b1.underflow), 32'd1);
        step1(1'b0, 8'h00, 1'b0, 1'b0);
        check("fwft_unf_held", 32'(b1.underflow), 32'd1);
        step1(1'b0, 8'h00, 1'b0, 1'b1);
        check("fwft_unf_clr", 32'(b1.underflow), 32'd0);
        step1(1'b1, 8'h11, 1'b0, 1'b0);
        step1(1'b1, 8'h22, 1'b0, 1'b0);
        check("fwft_head", 32'({b1.rd_data, b1.count}), 32'({8'h11, 5'd2}));
        step1(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_next", 32'({b1.rd_data, b1.rd_valid}), 32'({8'h22, 1'b1}));
        step1(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_drained", 32'({b1.empty, b1.rd_valid}), 32'b10);

        @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
